alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the datapath's combinational ALU.
- Keeps the original 2-bit operation encodings (ADD/SUB/SLL/SRA) and adds SRL, AND, OR and signed SLT.
- Adds zero and signed-overflow flags and a valid/ready handshake on both sides.
- Sits between the register-read stage and the writeback/memory stage, and can stall under back-pressure without losing or duplicating operations.

---
 rtl/alu_pipe_if.sv | 26 ++
 rtl/alu_pipe.sv | 115 +++++++++++
 tb/tb_alu_pipe.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand side (in_*) and result side (out_*).
// slave = the ALU, master = the producer/consumer driving it.
interface alu_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_ctl;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_ctl, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_ovf
   );

   modport master (
      output in_valid, in_ctl, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_ovf
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds operands, S2 holds result and flags.
// Ports: clk, rst (sync, active-high), io (alu_pipe_if.slave handshake bundle).
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic     clk,
   input logic     rst,
   alu_pipe_if.slave io
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_SLL = 3'd2;
   localparam logic [2:0] OP_SRA = 3'd3;
   localparam logic [2:0] OP_SRL = 3'd4;
   localparam logic [2:0] OP_AND = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_SLT = 3'd7;

   logic             s1_valid;
   logic [2:0]       s1_ctl;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_result;
   logic             s2_zero;
   logic             s2_ovf;

   logic             s2_adv;
   logic             s1_ready;

   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic             lt;
   logic [WIDTH-1:0] res;
   logic             ovf;

   // S1 may refill in the same cycle S2 drains, so in_ready
   // depends combinationally on out_ready.
   assign s2_adv   = !s2_valid || io.out_ready;
   assign s1_ready = !s1_valid || s2_adv;

   assign io.in_ready   = s1_ready;
   assign io.out_valid  = s2_valid;
   assign io.out_result = s2_result;
   assign io.out_zero   = s2_zero;
   assign io.out_ovf    = s2_ovf;

   assign shamt = s1_b[SHW-1:0];
   assign sum   = s1_a + s1_b;
   assign diff  = s1_a - s1_b;

   assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1])
                 && (sum[WIDTH-1] != s1_a[WIDTH-1]);
   assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1])
                 && (diff[WIDTH-1] != s1_a[WIDTH-1]);

   // Sign of A-B corrected by overflow gives the true signed compare.
   assign lt = diff[WIDTH-1] ^ sub_ovf;

   always_comb begin
      res = '0;
      ovf = 1'b0;
      unique case (s1_ctl)
         OP_ADD: begin
            res = sum;
            ovf = add_ovf;
         end
         OP_SUB: begin
            res = diff;
            ovf = sub_ovf;
         end
         OP_SLL: res = s1_a << shamt;
         OP_SRA: res = $unsigned($signed(s1_a) >>> shamt);
         OP_SRL: res = s1_a >> shamt;
         OP_AND: res = s1_a & s1_b;
         OP_OR:  res = s1_a | s1_b;
         OP_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_ctl    <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_zero   <= 1'b0;
         s2_ovf    <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid  <= s1_valid;
            s2_result <= res;
            s2_zero   <= (res == '0);
            s2_ovf    <= ovf;
         end
         if (s1_ready) begin
            s1_valid <= io.in_valid;
            if (io.in_valid) begin
               s1_ctl <= io.in_ctl;
               s1_a   <= io.in_a;
               s1_b   <= io.in_b;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32).
// Drives through alu_pipe_if, samples 1ns after each rising edge.
module tb_alu_pipe;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   alu_pipe_if #(.WIDTH(32)) bus ();

   alu_pipe #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op, then wait until its result is due in S2.
   task automatic exec(
      input  logic [2:0]  ctl,
      input  logic [31:0] a,
      input  logic [31:0] b,
      output logic        vld,
      output logic [31:0] res,
      output logic        zero,
      output logic        ovf
   );
      bus.in_valid = 1'b1;
      bus.in_ctl   = ctl;
      bus.in_a     = a;
      bus.in_b     = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      vld  = bus.out_valid;
      res  = bus.out_result;
      zero = bus.out_zero;
      ovf  = bus.out_ovf;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks += 4;
      if (bus.out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL rst_valid got %b want 0", bus.out_valid);
      end
      if (bus.out_result !== 32'h0) begin
         n_fails++;
         $display("FAIL rst_result got %h want 0", bus.out_result);
      end
      if ({bus.out_zero, bus.out_ovf} !== 2'b00) begin
         n_fails++;
         $display("FAIL rst_flags got %b%b want 00",
                  bus.out_zero, bus.out_ovf);
      end
      if (bus.in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_r [3];
      exp_r[0] = 32'd12;
      exp_r[1] = 32'hFFFF_FFF9;
      exp_r[2] = 32'h0000_F000;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_ctl = 3'd0; bus.in_a = 32'd5; bus.in_b = 32'd7;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL b2b_early got %b want 0", bus.out_valid);
      end
      bus.in_ctl = 3'd1; bus.in_a = 32'd3; bus.in_b = 32'd10;
      @(posedge clk); #1;
      bus.in_ctl = 3'd5; bus.in_a = 32'hF0F0; bus.in_b = 32'hFF00;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) bus.in_valid = 1'b0;
         n_checks++;
         if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_ovf}
             !== {1'b1, exp_r[i], 2'b00}) begin
            n_fails++;
            $display("FAIL b2b_%0d got v%b %h z%b o%b want v1 %h z0 o0",
                     i, bus.out_valid, bus.out_result, bus.out_zero,
                     bus.out_ovf, exp_r[i]);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL b2b_tail got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_vectors(
      input string       name,
      input logic [2:0]  ctl  [4],
      input logic [31:0] a    [4],
      input logic [31:0] b    [4],
      input logic [31:0] er   [4],
      input logic [1:0]  ezo  [4],
      input int          n
   );
      logic        v, z, o;
      logic [31:0] r;
      bus.out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         exec(ctl[i], a[i], b[i], v, r, z, o);
         n_checks++;
         if ({v, r, z, o} !== {1'b1, er[i], ezo[i]}) begin
            n_fails++;
            $display("FAIL %s_%0d got v%b %h z%b o%b want v1 %h zo%b",
                     name, i, v, r, z, o, er[i], ezo[i]);
         end
      end
   endtask

   task automatic test_overflow;
      logic [2:0]  c [4];
      logic [31:0] a [4], b [4], r [4];
      logic [1:0]  f [4];
      c[0] = 3'd0; a[0] = 32'h7FFF_FFFF; b[0] = 32'd1;
      r[0] = 32'h8000_0000; f[0] = 2'b01;
      c[1] = 3'd1; a[1] = 32'h8000_0000; b[1] = 32'd1;
      r[1] = 32'h7FFF_FFFF; f[1] = 2'b01;
      c[2] = 3'd1; a[2] = 32'd9; b[2] = 32'd9;
      r[2] = 32'h0; f[2] = 2'b10;
      c[3] = 3'd0; a[3] = 32'hFFFF_FFFF; b[3] = 32'd1;
      r[3] = 32'h0; f[3] = 2'b10;
      test_vectors("ovf", c, a, b, r, f, 4);
   endtask

   task automatic test_shift;
      logic [2:0]  c [4];
      logic [31:0] a [4], b [4], r [4];
      logic [1:0]  f [4];
      for (int i = 0; i < 4; i++) a[i] = 32'h8000_0010;
      c[0] = 3'd3; b[0] = 32'h24; r[0] = 32'hF800_0001; f[0] = 2'b00;
      c[1] = 3'd4; b[1] = 32'h24; r[1] = 32'h0800_0001; f[1] = 2'b00;
      c[2] = 3'd2; b[2] = 32'd31; r[2] = 32'h0;         f[2] = 2'b10;
      c[3] = 3'd3; b[3] = 32'd0;  r[3] = 32'h8000_0010; f[3] = 2'b00;
      test_vectors("shift", c, a, b, r, f, 4);
   endtask

   task automatic test_slt;
      logic [2:0]  c [4];
      logic [31:0] a [4], b [4], r [4];
      logic [1:0]  f [4];
      for (int i = 0; i < 4; i++) c[i] = 3'd7;
      a[0] = 32'h8000_0000; b[0] = 32'd1; r[0] = 32'd1; f[0] = 2'b00;
      a[1] = 32'd1; b[1] = 32'h8000_0000; r[1] = 32'd0; f[1] = 2'b10;
      a[2] = 32'h1234; b[2] = 32'h1234;   r[2] = 32'd0; f[2] = 2'b10;
      c[3] = 3'd6; a[3] = 32'h0F; b[3] = 32'hF0;
      r[3] = 32'hFF; f[3] = 2'b00;
      test_vectors("slt", c, a, b, r, f, 4);
   endtask

   task automatic test_backpressure;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_ctl = 3'd0; bus.in_a = 32'd1; bus.in_b = 32'd2;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL bp_rdy0 got %b want 1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_ctl = 3'd6; bus.in_a = 32'h0F; bus.in_b = 32'hF0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL bp_rdy1 got %b want 1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_ctl = 3'd4; bus.in_a = 32'h100; bus.in_b = 32'd4;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if ({bus.in_ready, bus.out_valid, bus.out_result}
             !== {2'b01, 32'd3}) begin
            n_fails++;
            $display("FAIL bp_hold_%0d got r%b v%b %h want r0 v1 3",
                     i, bus.in_ready, bus.out_valid, bus.out_result);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL bp_drain_rdy got %b want 1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_checks++;
      if ({bus.out_valid, bus.out_result} !== {1'b1, 32'hFF}) begin
         n_fails++;
         $display("FAIL bp_out1 got v%b %h want v1 ff",
                  bus.out_valid, bus.out_result);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({bus.out_valid, bus.out_result} !== {1'b1, 32'h10}) begin
         n_fails++;
         $display("FAIL bp_out2 got v%b %h want v1 10",
                  bus.out_valid, bus.out_result);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL bp_tail got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_flush;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_ctl = 3'd0; bus.in_a = 32'd100; bus.in_b = 32'd1;
      @(posedge clk); #1;
      bus.in_ctl = 3'd0; bus.in_a = 32'd200; bus.in_b = 32'd2;
      @(posedge clk); #1;
      bus.in_ctl = 3'd0; bus.in_a = 32'd300; bus.in_b = 32'd3;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      n_checks++;
      if ({bus.out_valid, bus.out_result, bus.in_ready}
          !== {1'b0, 32'h0, 1'b1}) begin
         n_fails++;
         $display("FAIL flush_state got v%b %h r%b want v0 0 r1",
                  bus.out_valid, bus.out_result, bus.in_ready);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_ctl = 3'd1; bus.in_a = 32'd50; bus.in_b = 32'd8;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL flush_stale got v%b %h want v0",
                  bus.out_valid, bus.out_result);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({bus.out_valid, bus.out_result} !== {1'b1, 32'd42}) begin
         n_fails++;
         $display("FAIL flush_new got v%b %h want v1 2a",
                  bus.out_valid, bus.out_result);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL flush_tail got v%b %h want v0",
                  bus.out_valid, bus.out_result);
      end
   endtask

   initial begin
      n_checks      = 0;
      n_fails       = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_ctl    = 3'd0;
      bus.in_a      = 32'h0;
      bus.in_b      = 32'h0;
      bus.out_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_overflow();
      test_shift();
      test_slt();
      @(posedge clk); #1;
      test_backpressure();
      test_reset_flush();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
